// File: rtl/niosii_sys_sw_ctrl.sv
// Switch-input controller: 2-flop sync, optional debounce (SW_CTRL_DEBOUNCE_EN), per-bit
// edge capture with W1C clear, maskable level irq and an Avalon-MM slave register port.
module niosii_sys_sw_ctrl #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned STABLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] AddrData = 2'd0;
  localparam logic [1:0] AddrMask = 2'd1;
  localparam logic [1:0] AddrEdge = 2'd2;
  localparam logic [1:0] AddrCfg  = 2'd3;

  if (WIDTH < 1 || WIDTH > 32 || DIV < 1 || STABLE < 2 || STABLE > 15) begin : g_param_check
    $error("niosii_sys_sw_ctrl: parameter out of range");
  end

  logic [WIDTH-1:0] r_sync1, r_sync2;
  logic [WIDTH-1:0] r_deb, r_init;
  logic [WIDTH-1:0] r_deb_prev, r_init_prev;
  logic [WIDTH-1:0] r_mask, r_edge;
  logic [1:0]       r_cfg;
  logic [31:0]      r_readdata;
  logic [WIDTH-1:0] w_rise, w_fall, w_clr;
  logic             w_wr, w_rd;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // Left unreset so that deb picks up the true pin level right after reset.
  always_ff @(posedge clk) begin
    r_sync1 <= in_port;
    r_sync2 <= r_sync1;
  end

`ifdef SW_CTRL_DEBOUNCE_EN
  localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TickAt    = PW'(DIV - 1);
  localparam logic [3:0]    StableCnt = 4'(STABLE);

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [3:0]    r_cnt [WIDTH];

  assign w_tick = (r_presc == TickAt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb  <= '0;
      r_init <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] + 4'd1 == StableCnt) begin
          r_deb[i]  <= r_sync2[i];
          r_init[i] <= 1'b1;
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 4'd1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb  <= '0;
      r_init <= '0;
    end else begin
      r_deb  <= r_sync2;
      r_init <= '1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb_prev  <= '0;
      r_init_prev <= '0;
    end else begin
      r_deb_prev  <= r_deb;
      r_init_prev <= r_init;
    end
  end

  assign w_wr = chipselect & ~write_n;
  assign w_rd = chipselect & write_n;

  // Qualify with the delayed init so the acceptance that sets init is never an edge.
  assign w_rise = r_deb & ~r_deb_prev & r_init_prev & {WIDTH{r_cfg[0]}};
  assign w_fall = ~r_deb & r_deb_prev & r_init_prev & {WIDTH{r_cfg[1]}};
  assign w_clr  = (w_wr && address == AddrEdge) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '0;
      r_edge <= '0;
      r_cfg  <= 2'b01;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_rise | w_fall;
      if (w_wr && address == AddrMask) r_mask <= writedata[WIDTH-1:0];
      if (w_wr && address == AddrCfg)  r_cfg  <= writedata[1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      AddrData: w_rdata[WIDTH-1:0] = r_deb;
      AddrMask: w_rdata[WIDTH-1:0] = r_mask;
      AddrEdge: w_rdata[WIDTH-1:0] = r_edge;
      default:  w_rdata[1:0]       = r_cfg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_mask);
  assign w_unused = ^writedata;

endmodule

// File: tb/tb_niosii_sys_sw_ctrl.sv
// Scoreboard bench for niosii_sys_sw_ctrl: reads push expected values from a settled-level
// model; a monitor pops and compares after each read edge. Works with or without debounce.
module tb_niosii_sys_sw_ctrl;

  localparam int unsigned W = 10;
`ifdef SW_CTRL_DEBOUNCE_EN
  localparam bit DebOn  = 1'b1;
  localparam int Settle = 24;
  localparam int IrqLo  = 10;
  localparam int IrqHi  = 19;
`else
  localparam bit DebOn  = 1'b0;
  localparam int Settle = 6;
  localparam int IrqLo  = 4;
  localparam int IrqHi  = 4;
`endif

  logic          clk;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  niosii_sys_sw_ctrl #(
    .WIDTH  (W),
    .DIV    (4),
    .STABLE (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Settled-level model of the register file.
  logic [W-1:0] m_deb, m_edge, m_mask;
  logic [1:0]   m_cfg;

  function automatic logic [W-1:0] edges_of(input logic [W-1:0] from_lvl,
                                            input logic [W-1:0] to_lvl,
                                            input logic [1:0] cfg);
    return ((to_lvl & ~from_lvl) & {W{cfg[0]}}) | ((from_lvl & ~to_lvl) & {W{cfg[1]}});
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    case (a)
      2'd1:    m_mask = d[W-1:0];
      2'd2:    m_edge = m_edge & ~d[W-1:0];
      2'd3:    m_cfg  = d[1:0];
      default: ;
    endcase
  endtask

  task automatic rd(input logic [1:0] a);
    exp_t e;
    e.addr = a;
    case (a)
      2'd0:    e.val = 32'(m_deb);
      2'd1:    e.val = 32'(m_mask);
      2'd2:    e.val = 32'(m_edge);
      default: e.val = {30'b0, m_cfg};
    endcase
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic check_irq(input string name);
    logic exp_irq;
    exp_irq = |(m_edge & m_mask);
    total++;
    if (irq !== exp_irq) begin
      bad++;
      $display("FAIL %s: irq=%b expected %b", name, irq, exp_irq);
    end
  endtask

  task automatic settle_to(input logic [W-1:0] pat);
    @(negedge clk);
    in_port = pat;
    idle(Settle);
    m_edge = m_edge | edges_of(m_deb, pat, m_cfg);
    m_deb  = pat;
  endtask

  // Short pulse: filtered out with debounce, seen as two transitions without it.
  task automatic glitch(input logic [W-1:0] bits, input int len);
    logic [W-1:0] g;
    g = m_deb ^ bits;
    @(negedge clk);
    in_port = g;
    idle(len);
    in_port = m_deb;
    idle(Settle);
    if (!DebOn) m_edge = m_edge | edges_of(m_deb, g, m_cfg) | edges_of(g, m_deb, m_cfg);
  endtask

  task automatic edge_timing(input int b, input string name);
    logic [W-1:0] bm;
    int k;
    bit seen;
    bm = W'(1) << b;
    seen = 1'b0;
    @(negedge clk);
    in_port = m_deb | bm;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen || k < IrqLo || k > IrqHi) begin
      bad++;
      $display("FAIL %s: irq rose after %0d cycles (seen=%0d), allowed %0d..%0d",
               name, k, seen, IrqLo, IrqHi);
    end
    m_edge = m_edge | edges_of(m_deb, m_deb | bm, m_cfg);
    m_deb  = m_deb | bm;
    idle(Settle);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (chipselect && write_n && !reset) begin
        #1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: readdata=%h with no expected entry", readdata);
        end else begin
          e = exp_q.pop_front();
          if (readdata !== e.val) begin
            bad++;
            $display("FAIL rd_addr%0d: readdata=%h expected %h", e.addr, readdata, e.val);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W-1:0] bm;
    int k;
    bit seen;
    in_port = '1; reset = 1'b1; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    idle(4);
    total++;
    if (readdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_readdata: readdata=%h expected 0", readdata);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: irq=%b expected 0", irq);
    end
    reset = 1'b0;
    m_deb = '1; m_edge = '0; m_mask = '0; m_cfg = 2'b01;
    idle(40);

    // Startup with all switches high: level accepted, no edges.
    rd(2'd0); rd(2'd2); rd(2'd1); rd(2'd3);
    check_irq("s1_irq");
    idle(3);
    total++;
    if (readdata !== 32'h1) begin
      bad++;
      $display("FAIL rd_hold: readdata=%h expected 00000001", readdata);
    end
    wr(2'd0, 32'h0000_0155);
    rd(2'd0);

    // Rising edge on bit 0 raises irq, W1C clears it.
    settle_to(10'h3F6);
    wr(2'd1, 32'h1);
    check_irq("s2_irq_before");
    edge_timing(0, "s2_irq_latency");
    rd(2'd0); rd(2'd2);
    check_irq("s2_irq_after");
    wr(2'd2, 32'h1);
    check_irq("s2_w1c_irq");
    rd(2'd2);

    // Short glitch on bit 3.
    glitch(10'h008, 3);
    idle(40);
    rd(2'd0); rd(2'd2);

    // Fall-only capture on bit 5.
    wr(2'd3, 32'h2);
    settle_to(m_deb & ~10'h020);
    wr(2'd2, 32'h3FF);
    settle_to(m_deb | 10'h020);
    settle_to(m_deb);
    settle_to(m_deb & ~10'h020);
    rd(2'd2);
    wr(2'd1, 32'h20);
    check_irq("s4_irq_enabled");
    wr(2'd1, 32'h0);
    check_irq("s4_irq_masked");

    // W1C of bit 2 held every cycle across the moment its edge sets: set must win.
    wr(2'd3, 32'h1);
    settle_to(m_deb & ~10'h004);
    wr(2'd2, 32'h3FF);
    wr(2'd1, 32'h4);
    bm = 10'h004;
    @(negedge clk);
    in_port = m_deb | bm;
    address = 2'd2; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h4;
    seen = 1'b0;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL s5_set_wins: irq=0 after 30 cycles of colliding W1C, expected 1");
    end
    m_edge = m_edge | edges_of(m_deb, m_deb | bm, m_cfg);
    m_deb  = m_deb | bm;
    idle(Settle);
    rd(2'd2);
    check_irq("s5_irq");

    // Rise latency on bit 7.
    settle_to(m_deb & ~10'h080);
    wr(2'd2, 32'h3FF);
    wr(2'd1, 32'h80);
    check_irq("s6_irq_before");
    edge_timing(7, "s6_irq_latency");
    rd(2'd0); rd(2'd2);
    check_irq("s6_irq_after");

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 5))
        0:       settle_to(W'($urandom));
        1:       glitch(W'($urandom), int'($urandom_range(1, 3)));
        2:       wr(2'd1, $urandom);
        3:       wr(2'd3, $urandom);
        4:       wr(2'd2, $urandom);
        default: wr(2'd0, $urandom);
      endcase
      rd(2'd0); rd(2'd2);
      if (it % 4 == 0) begin
        rd(2'd1); rd(2'd3);
      end
      check_irq("rand_irq");
    end

    // Reset mid-operation with an edge pending.
    wr(2'd3, 32'h3);
    wr(2'd1, 32'h3FF);
    wr(2'd2, 32'h3FF);
    settle_to(m_deb ^ 10'h001);
    check_irq("pre_reset_irq");
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL midreset_irq: irq=%b expected 0", irq);
    end
    total++;
    if (readdata !== 32'h0) begin
      bad++;
      $display("FAIL midreset_readdata: readdata=%h expected 0", readdata);
    end
    m_edge = '0; m_mask = '0; m_cfg = 2'b01;
    idle(3);
    reset = 1'b0;
    idle(40);
    rd(2'd0); rd(2'd2); rd(2'd1); rd(2'd3);
    check_irq("post_reset_irq");

    idle(4);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
